// File: rtl/core_pkg.sv
// Shared types, instruction field layout and branch target table for core_pipe2.
// Field layout (IW bits): op[IW-1:IW-4] | rB[IW-5:IW-6] | rA/imm[2:0].
// ADDI uses the rB field as its destination/source register and [2:0] as the immediate.
// The same applies to BEQ/JMP, whose [2:0] field indexes the branch target table.
// SHL/SHR shift rA by one bit; carry takes the bit shifted out.
package core_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned RB_W  = 2;
   localparam int unsigned RA_W  = 3;
   localparam int unsigned LUT_W = 16;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 4'h0,
      OP_ADD   = 4'h1,
      OP_SUB   = 4'h2,
      OP_AND   = 4'h3,
      OP_OR    = 4'h4,
      OP_XOR   = 4'h5,
      OP_SHL   = 4'h6,
      OP_SHR   = 4'h7,
      OP_ADDI  = 4'h8,
      OP_LOAD  = 4'h9,
      OP_STORE = 4'hA,
      OP_BEQ   = 4'hB,
      OP_JMP   = 4'hC,
      OP_HALT  = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      ALU_NONE,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SHL,
      ALU_SHR
   } alu_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } run_state_t;

   // Map an opcode onto the ALU operation it needs (ALU_NONE for non-ALU ops).
   function automatic alu_cmd_t alu_of(input opcode_t op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB:          return ALU_SUB;
         OP_AND:          return ALU_AND;
         OP_OR:           return ALU_OR;
         OP_XOR:          return ALU_XOR;
         OP_SHL:          return ALU_SHL;
         OP_SHR:          return ALU_SHR;
         default:         return ALU_NONE;
      endcase
   endfunction

   // Branch target table: entry n holds PC 10*n (0, 10, 20, ... 70).
   function automatic logic [LUT_W-1:0] pc_lut(input logic [RA_W-1:0] idx);
      return LUT_W'(idx) * LUT_W'(10);
   endfunction

endpackage

// File: rtl/run_ctrl.sv
// Run control: req edge detection, IDLE/RUN/DONE sequencing, fetch enable and done.
// A stop request (HALT retired or PC limit reached) is held for one cycle so the
// pipeline drains before DONE is entered.
module run_ctrl import core_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       halt_c,
   input  logic       limit_c,
   output run_state_t state,
   output logic       done,
   output logic       start_c,
   output logic       fetch_en_c
);

   run_state_t state_d;
   logic       req_q;
   logic       stop_q;
   logic       stop_d;
   logic       done_d;
   logic       req_rise_c;

   assign req_rise_c = req && !req_q;

   // State, stop flag, done and req history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         stop_q <= 1'b0;
         done   <= 1'b0;
         req_q  <= 1'b0;
      end else begin
         state  <= state_d;
         stop_q <= stop_d;
         done   <= done_d;
         req_q  <= req;
      end
   end

   // Next-state, start strobe and fetch enable.
   always_comb begin
      state_d    = state;
      stop_d     = stop_q;
      start_c    = 1'b0;
      fetch_en_c = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (req_rise_c) begin
               state_d = RUN;
               stop_d  = 1'b0;
               start_c = 1'b1;
            end
         end
         RUN: begin
            fetch_en_c = !stop_q;
            if (stop_q) begin
               state_d = DONE;
               stop_d  = 1'b0;
            end else if (halt_c || limit_c) begin
               stop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
   end

endmodule

// File: rtl/core_pipe2.sv
// Two-stage core (fetch | decode/execute/writeback) with run control.
// Optional feature macro: PERF_CNT_EN adds cyc_cnt/ins_cnt performance counters.
module core_pipe2 import core_pkg::*; #(
   parameter int unsigned D        = 12,
   parameter int unsigned IW       = 9,
   parameter int unsigned DW       = 8,
   parameter int unsigned NREG     = 8,
   parameter int unsigned PC_LIMIT = 128
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic [D-1:0]  imem_addr,
   input  logic [IW-1:0] imem_data,
   output logic [DW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   output logic          dmem_we,
   input  logic [DW-1:0] dmem_rdata
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ins_cnt
`endif
);

   localparam int unsigned RW     = $clog2(NREG);
   localparam int unsigned OP_LSB = IW - OP_W;
   localparam int unsigned RB_LSB = OP_LSB - RB_W;

   run_state_t     state;
   logic           start_c;
   logic           fetch_en_c;
   logic           halt_c;
   logic           limit_c;
   logic           take_br_c;

   logic [D-1:0]   pc;
   logic [IW-1:0]  ir;
   logic           f_valid;
   logic [DW-1:0]  regs [NREG];
   logic           zero_q;
   logic           carry_q;

   opcode_t        op_c;
   alu_cmd_t       alu_c;
   logic [RA_W-1:0] imm_c;
   logic [RW-1:0]  ra_c;
   logic [RW-1:0]  rb_c;
   logic [RW-1:0]  dst_c;
   logic           e_act_c;
   logic [DW-1:0]  opa_c;
   logic [DW-1:0]  opb_c;
   logic [DW:0]    ext_c;
   logic [DW-1:0]  alu_res_c;
   logic           alu_carry_c;
   logic [D-1:0]   br_target_c;

   run_ctrl u_run_ctrl (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .halt_c     (halt_c),
      .limit_c    (limit_c),
      .state      (state),
      .done       (done),
      .start_c    (start_c),
      .fetch_en_c (fetch_en_c)
   );

   // Instruction decode of the E-stage register.
   assign op_c    = opcode_t'(ir[OP_LSB +: OP_W]);
   assign imm_c   = ir[RA_W-1:0];
   assign ra_c    = RW'(imm_c);
   assign rb_c    = RW'(ir[RB_LSB +: RB_W]);
   assign dst_c   = (op_c == OP_ADDI) ? rb_c : ra_c;
   assign alu_c   = alu_of(op_c);
   assign e_act_c = f_valid && (state == RUN);

   // Control-flow decisions; a taken branch overrides the PC limit.
   assign take_br_c   = e_act_c && ((op_c == OP_JMP) || ((op_c == OP_BEQ) && zero_q));
   assign halt_c      = e_act_c && (op_c == OP_HALT);
   assign limit_c     = fetch_en_c && (pc == D'(PC_LIMIT)) && !take_br_c;
   assign br_target_c = D'(pc_lut(imm_c));

   // Data memory port; the store strobe is dropped while reset is asserted.
   assign imem_addr  = pc;
   assign dmem_addr  = regs[ra_c];
   assign dmem_wdata = regs[rb_c];
   assign dmem_we    = e_act_c && (op_c == OP_STORE) && !reset;

   // ALU: result plus carry/borrow/shifted-out bit in ext_c[DW].
   always_comb begin
      opa_c = regs[dst_c];
      opb_c = (op_c == OP_ADDI) ? DW'(imm_c) : regs[rb_c];
      ext_c = '0;
      case (alu_c)
         ALU_ADD: ext_c = {1'b0, opa_c} + {1'b0, opb_c};
         ALU_SUB: ext_c = {1'b0, opa_c} - {1'b0, opb_c};
         ALU_AND: ext_c = {1'b0, opa_c & opb_c};
         ALU_OR:  ext_c = {1'b0, opa_c | opb_c};
         ALU_XOR: ext_c = {1'b0, opa_c ^ opb_c};
         ALU_SHL: ext_c = {opa_c, 1'b0};
         ALU_SHR: ext_c = {opa_c[0], 1'b0, opa_c[DW-1:1]};
         default: ext_c = '0;
      endcase
      alu_res_c   = ext_c[DW-1:0];
      alu_carry_c = ext_c[DW];
   end

   // Fetch stage and PC: flush on start, squash on branch/halt/limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= '0;
         ir      <= '0;
         f_valid <= 1'b0;
      end else if (start_c) begin
         pc      <= '0;
         f_valid <= 1'b0;
      end else if (!fetch_en_c || take_br_c || halt_c || limit_c) begin
         f_valid <= 1'b0;
         if (take_br_c) begin
            pc <= br_target_c;
         end
      end else begin
         ir      <= imem_data;
         f_valid <= 1'b1;
         pc      <= pc + D'(1);
      end
   end

   // Register file and flag writeback; state persists across runs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else if (e_act_c) begin
         if (alu_c != ALU_NONE) begin
            regs[dst_c] <= alu_res_c;
            zero_q      <= (alu_res_c == '0);
            carry_q     <= alu_carry_c;
         end else if (op_c == OP_LOAD) begin
            regs[ra_c] <= dmem_rdata;
         end
      end
   end

`ifdef PERF_CNT_EN
   // Saturating RUN-cycle and retired-instruction counters, cleared at run start.
   always_ff @(posedge clk) begin
      if (reset || start_c) begin
         cyc_cnt <= '0;
         ins_cnt <= '0;
      end else if (state == RUN) begin
         if (cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
         end
         if (e_act_c && (ins_cnt != '1)) begin
            ins_cnt <= ins_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
